// File: rtl/lieat_ifu_bpu.sv
// lieat_ifu_bpu: IFU pre-decode and registered branch prediction (bimodal BHT,
// optional return-address stack enabled by defining LIEAT_BPU_RAS_EN).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_IDX
`define REG_IDX 5
`endif

module lieat_ifu_bpu #(
  parameter int BHT_DEPTH = 64,
  parameter int RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  input  logic [`XLEN-1:0]    if_pc,
  input  logic [`XLEN-1:0]    if_inst,
  input  logic [`XLEN-1:0]    if_rs1_val,
  output logic [`REG_IDX-1:0] dec_rs1,
  output logic                dec_rs1en,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [`XLEN-1:0]    pred_target,
  output logic                pred_fencei,
  input  logic                exu_upd_valid,
  input  logic [`XLEN-1:0]    exu_upd_pc,
  input  logic                exu_upd_taken,
  input  logic                flush
);

  localparam int XW     = `XLEN;
  localparam int BHT_AW = $clog2(BHT_DEPTH);

  localparam logic [6:0]    OPC_JAL    = 7'b1101111;
  localparam logic [6:0]    OPC_JALR   = 7'b1100111;
  localparam logic [6:0]    OPC_BXX    = 7'b1100011;
  localparam logic [6:0]    OPC_FENCE  = 7'b0001111;
  localparam logic [2:0]    F3_FENCEI  = 3'b001;
  localparam logic [1:0]    BHT_INIT   = 2'b01;
  localparam logic [XW-1:0] PC_STEP    = XW'(4);
  localparam logic [XW-1:0] ALIGN_MASK = ~(XW'(1));

  // x1 (ra) and x5 (t0) are the architectural link registers
  function automatic logic is_link(input logic [`REG_IDX-1:0] r);
    return (r == `REG_IDX'(1)) || (r == `REG_IDX'(5));
  endfunction

  function automatic logic [1:0] bht_next(input logic [1:0] c, input logic t);
    logic [1:0] n;
    n = c;
    if (t) begin
      if (c != 2'b11) n = c + 2'b01;
      else            n = c;
    end else begin
      if (c != 2'b00) n = c - 2'b01;
      else            n = c;
    end
    return n;
  endfunction

  logic [6:0]    opc_s;
  logic          is_jal_s, is_jalr_s, is_bxx_s, is_fencei_s;
  logic [XW-1:0] imm_j_s, imm_b_s, imm_i_s;
  logic [XW-1:0] pc_plus4_s, jalr_fb_s, ras_top_s;
  logic          use_ras_s, fire_s;

  assign opc_s       = if_inst[6:0];
  assign is_jal_s    = (opc_s == OPC_JAL);
  assign is_jalr_s   = (opc_s == OPC_JALR);
  assign is_bxx_s    = (opc_s == OPC_BXX);
  assign is_fencei_s = (opc_s == OPC_FENCE) && (if_inst[14:12] == F3_FENCEI);

  assign dec_rs1   = if_inst[19:15];
  assign dec_rs1en = is_jalr_s;

  assign imm_j_s = {{(XW-21){if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20],
                    if_inst[30:21], 1'b0};
  assign imm_b_s = {{(XW-13){if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25],
                    if_inst[11:8], 1'b0};
  assign imm_i_s = {{(XW-12){if_inst[31]}}, if_inst[31:20]};

  assign pc_plus4_s = if_pc + PC_STEP;
  assign jalr_fb_s  = (if_rs1_val + imm_i_s) & ALIGN_MASK;
  assign fire_s     = if_valid & ~flush;

  // Bimodal history table
  logic [1:0]        bht_q [BHT_DEPTH];
  logic [BHT_AW-1:0] lkp_idx_s, upd_idx_s;
  logic              unused_upd_pc_s;

  assign lkp_idx_s       = if_pc[BHT_AW+1:2];
  assign upd_idx_s       = exu_upd_pc[BHT_AW+1:2];
  assign unused_upd_pc_s = ^{exu_upd_pc[1:0], exu_upd_pc[XW-1:BHT_AW+2]};

  // BHT training from EXU resolution; the lookup above sees the pre-edge value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= BHT_INIT;
    end else if (exu_upd_valid) begin
      bht_q[upd_idx_s] <= bht_next(bht_q[upd_idx_s], exu_upd_taken);
    end
  end

`ifdef LIEAT_BPU_RAS_EN
  localparam int              RAS_AW   = $clog2(RAS_DEPTH);
  localparam logic [RAS_AW:0] RAS_FULL = (RAS_AW+1)'(RAS_DEPTH);

  logic [XW-1:0]     ras_q [RAS_DEPTH];
  logic [RAS_AW-1:0] ras_ptr_q, ras_top_idx_s;
  logic [RAS_AW:0]   ras_cnt_q;
  logic              rd_link_s, rs1_link_s, ras_push_s, ras_pop_s, ras_nonempty_s;

  assign rd_link_s      = is_link(if_inst[11:7]);
  assign rs1_link_s     = is_link(if_inst[19:15]);
  // Linking rd == rs1 is a plain call (push only); any other linking rs1 pops
  assign ras_pop_s      = is_jalr_s & rs1_link_s &
                          ~(rd_link_s & (if_inst[11:7] == if_inst[19:15]));
  assign ras_push_s     = (is_jal_s | is_jalr_s) & rd_link_s;
  assign ras_nonempty_s = (ras_cnt_q != '0);
  assign ras_top_idx_s  = ras_ptr_q - RAS_AW'(1);
  assign ras_top_s      = ras_q[ras_top_idx_s];
  assign use_ras_s      = ras_pop_s & ras_nonempty_s;

  // Circular return stack: ptr is the next free slot, overflow drops the oldest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else if (fire_s) begin
      if (ras_pop_s && ras_push_s && ras_nonempty_s) begin
        ras_q[ras_top_idx_s] <= pc_plus4_s;
      end else if (ras_push_s) begin
        ras_q[ras_ptr_q] <= pc_plus4_s;
        ras_ptr_q        <= ras_ptr_q + RAS_AW'(1);
        if (ras_cnt_q != RAS_FULL) ras_cnt_q <= ras_cnt_q + (RAS_AW+1)'(1);
      end else if (ras_pop_s && ras_nonempty_s) begin
        ras_ptr_q <= ras_top_idx_s;
        ras_cnt_q <= ras_cnt_q - (RAS_AW+1)'(1);
      end
    end
  end
`else
  assign use_ras_s = 1'b0;
  assign ras_top_s = '0;
`endif

  logic          taken_d, fencei_d;
  logic [XW-1:0] target_d;

  // Per-type prediction
  always_comb begin
    taken_d  = 1'b0;
    target_d = pc_plus4_s;
    fencei_d = is_fencei_s;
    if (is_jal_s) begin
      taken_d  = 1'b1;
      target_d = if_pc + imm_j_s;
    end else if (is_jalr_s) begin
      taken_d  = 1'b1;
      target_d = use_ras_s ? ras_top_s : jalr_fb_s;
    end else if (is_bxx_s) begin
      taken_d  = bht_q[lkp_idx_s][1];
      target_d = bht_q[lkp_idx_s][1] ? (if_pc + imm_b_s) : pc_plus4_s;
    end else begin
      taken_d  = 1'b0;
      target_d = pc_plus4_s;
    end
  end

  logic          pred_valid_q, pred_taken_q, pred_fencei_q;
  logic [XW-1:0] pred_target_q;

  // Prediction register; payload holds while no new fetch is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      pred_fencei_q <= 1'b0;
    end else begin
      pred_valid_q <= fire_s;
      if (fire_s) begin
        pred_taken_q  <= taken_d;
        pred_target_q <= target_d;
        pred_fencei_q <= fencei_d;
      end
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign pred_fencei = pred_fencei_q;

endmodule
